// File: rtl/commit_trace_buffer.sv
// Purpose : receive side of the core commit-trace port; queues retired instructions
//           and drains them in order through a valid/ready record port.
// Latency : a record pushed on edge N is visible on rec_* after edge N (no bypass).
// Backpressure: when full and not popping, new commits are dropped and counted.
//           Full + pop in the same cycle still accepts the commit.
//
// Ports:
//   clk_i, rst_i           clock (rising edge), asynchronous active-high reset
//   commit_valid_i         one retired instruction this cycle
//   pc_i, instr_i          PC and instruction word of the retired instruction
//   reg_addr_i/_data_i     destination register and write-back data
//   reg_update_i           register file written
//   rec_valid_o/rec_ready_i  head record handshake
//   rec_pc_o, rec_instr_o, rec_addr_o, rec_data_o, rec_update_o  head record fields
//   level_o                entries currently held
//   commit_cnt_o           accepted commits, wraps
//   drop_cnt_o             dropped commits, saturates
//   overflow_o             sticky drop flag
//   clear_i                synchronous clear of FIFO, counters and overflow
module commit_trace_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     commit_valid_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [XLEN-1:0]          instr_i,
  input  logic [4:0]               reg_addr_i,
  input  logic [XLEN-1:0]          reg_data_i,
  input  logic                     reg_update_i,
  output logic                     rec_valid_o,
  input  logic                     rec_ready_i,
  output logic [XLEN-1:0]          rec_pc_o,
  output logic [XLEN-1:0]          rec_instr_o,
  output logic [4:0]               rec_addr_o,
  output logic [XLEN-1:0]          rec_data_o,
  output logic                     rec_update_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [31:0]              commit_cnt_o,
  output logic [15:0]              drop_cnt_o,
  output logic                     overflow_o,
  input  logic                     clear_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Storage, one array per record field so each output is a plain read mux.
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [4:0]      addr_mem  [DEPTH];
  logic [XLEN-1:0] data_mem  [DEPTH];
  logic            upd_mem   [DEPTH];

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_nxt;
  logic [PW-1:0] rd_ptr_nxt;
  logic [PW-1:0] level_nxt;
  logic          valid_q;

  logic full;
  logic pop;
  logic push;
  logic drop;
  logic upd_eff;

  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];

  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);

  // Pop keys off the registered valid, so ready while empty does nothing.
  assign pop  = valid_q && rec_ready_i && !clear_i;
  // A same-cycle pop frees the slot the push needs, so full+pop is not a drop.
  assign push = commit_valid_i && (!full || pop) && !clear_i;
  assign drop = commit_valid_i && full && !pop && !clear_i;

  // Writes to x0 never change architectural state; log them as no-update.
  assign upd_eff = reg_update_i && (reg_addr_i != 5'd0);

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (clear_i) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end else begin
      if (push) wr_ptr_nxt = wr_ptr + PW'(1);
      if (pop)  rd_ptr_nxt = rd_ptr + PW'(1);
    end
    level_nxt = wr_ptr_nxt - rd_ptr_nxt;
  end

  // Pointers and the registered valid flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      valid_q <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      valid_q <= (level_nxt != '0);
    end
  end

  // Storage is reset too, so the record outputs read as zero straight out of reset.
  // Clear only moves the pointers; stale contents are hidden behind rec_valid_o=0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
        addr_mem[i]  <= '0;
        data_mem[i]  <= '0;
        upd_mem[i]   <= 1'b0;
      end
    end else if (push) begin
      pc_mem[wr_idx]    <= pc_i;
      instr_mem[wr_idx] <= instr_i;
      addr_mem[wr_idx]  <= reg_addr_i;
      data_mem[wr_idx]  <= reg_data_i;
      upd_mem[wr_idx]   <= upd_eff;
    end
  end

  // Statistics: commits count only accepted records; drops saturate so a long
  // stall never wraps back to a reassuring small number.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      commit_cnt_o <= '0;
      drop_cnt_o   <= '0;
      overflow_o   <= 1'b0;
    end else if (clear_i) begin
      commit_cnt_o <= '0;
      drop_cnt_o   <= '0;
      overflow_o   <= 1'b0;
    end else begin
      if (push) commit_cnt_o <= commit_cnt_o + 32'd1;
      if (drop) begin
        overflow_o <= 1'b1;
        if (drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
      end
    end
  end

  // Head record comes straight from storage at the read pointer; it cannot
  // change while stalled because only a pop moves rd_ptr.
  assign rec_valid_o  = valid_q;
  assign rec_pc_o     = pc_mem[rd_idx];
  assign rec_instr_o  = instr_mem[rd_idx];
  assign rec_addr_o   = addr_mem[rd_idx];
  assign rec_data_o   = data_mem[rd_idx];
  assign rec_update_o = upd_mem[rd_idx];
  assign level_o      = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Purpose : directed bench for commit_trace_buffer (XLEN=32, DEPTH=8).
// Latency : inputs driven and outputs sampled 1ns after each rising edge.
// Backpressure: exercised via rec_ready_i patterns and a small in-order scoreboard.
module tb_commit_trace_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;
  logic        reg_update;
  logic        rec_valid;
  logic        rec_ready;
  logic [31:0] rec_pc;
  logic [31:0] rec_instr;
  logic [4:0]  rec_addr;
  logic [31:0] rec_data;
  logic        rec_update;
  logic [3:0]  level;
  logic [31:0] commit_cnt;
  logic [15:0] drop_cnt;
  logic        overflow;
  logic        clear;

  int n_checks = 0;
  int n_err    = 0;

  commit_trace_buffer #(.XLEN(32), .DEPTH(8)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .commit_valid_i (commit_valid),
    .pc_i           (pc),
    .instr_i        (instr),
    .reg_addr_i     (reg_addr),
    .reg_data_i     (reg_data),
    .reg_update_i   (reg_update),
    .rec_valid_o    (rec_valid),
    .rec_ready_i    (rec_ready),
    .rec_pc_o       (rec_pc),
    .rec_instr_o    (rec_instr),
    .rec_addr_o     (rec_addr),
    .rec_data_o     (rec_data),
    .rec_update_o   (rec_update),
    .level_o        (level),
    .commit_cnt_o   (commit_cnt),
    .drop_cnt_o     (drop_cnt),
    .overflow_o     (overflow),
    .clear_i        (clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one commit; instr is derived from pc so it can be checked too.
  task automatic drive(input logic [31:0] p, input logic [4:0] a,
                       input logic [31:0] d, input logic u);
    commit_valid = 1'b1;
    pc           = p;
    instr        = p ^ 32'h0000_0013;
    reg_addr     = a;
    reg_data     = d;
    reg_update   = u;
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] sb_pc[$];
  logic [31:0] sb_data[$];
  logic        sb_upd[$];
  logic [31:0] held_pc;
  logic [31:0] held_data;
  logic        stalled;
  int          popped;

  initial begin
    rst = 1'b1; commit_valid = 1'b0; pc = '0; instr = '0; reg_addr = '0;
    reg_data = '0; reg_update = 1'b0; rec_ready = 1'b0; clear = 1'b0;
    #2;
    check("rst_valid", rec_valid, 0);
    check("rst_level", level, 0);
    check("rst_pc", rec_pc, 0);
    check("rst_commit_cnt", commit_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_overflow", overflow, 0);
    step(); step();
    rst = 1'b0;

    // Three commits with ready held high: level never exceeds 1.
    rec_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(32'(4 * k), 5'd1, 32'(k), 1'b1);
      step();
      check("flow_valid", rec_valid, 1);
      check("flow_pc", rec_pc, 64'(4 * k));
      check("flow_instr", rec_instr, 64'((4 * k) ^ 32'h13));
      check("flow_level", level, 1);
    end
    commit_valid = 1'b0;
    step();
    check("flow_empty_level", level, 0);
    check("flow_empty_valid", rec_valid, 0);
    check("flow_commit_cnt", commit_cnt, 3);

    // Ten commits into a stalled 8-deep FIFO: two dropped.
    rec_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(32'h100 + 32'(4 * i), 5'd2, 32'(i), 1'b1);
      step();
    end
    commit_valid = 1'b0;
    check("ovf_level", level, 8);
    check("ovf_drop_cnt", drop_cnt, 2);
    check("ovf_flag", overflow, 1);
    check("ovf_commit_cnt", commit_cnt, 11);
    rec_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("ovf_drain_valid", rec_valid, 1);
      check("ovf_drain_pc", rec_pc, 64'(32'h100 + 32'(4 * i)));
      step();
    end
    check("ovf_drained_level", level, 0);
    check("ovf_drained_valid", rec_valid, 0);

    // Full, then commit and pop in the same cycle.
    rec_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(32'h200 + 32'(4 * i), 5'd3, 32'(i), 1'b1);
      step();
    end
    check("full_level", level, 8);
    rec_ready = 1'b1;
    drive(32'h300, 5'd3, 32'h9, 1'b1);
    step();
    commit_valid = 1'b0;
    check("fullpop_level", level, 8);
    check("fullpop_drop_cnt", drop_cnt, 2);
    check("fullpop_commit_cnt", commit_cnt, 20);
    exp_q = {};
    for (int i = 1; i < 8; i++) exp_q.push_back(32'h200 + 32'(4 * i));
    exp_q.push_back(32'h300);
    for (int i = 0; i < 8; i++) begin
      check("fullpop_order", rec_pc, 64'(exp_q[i]));
      step();
    end
    check("fullpop_empty", level, 0);

    // Writes to x0 are logged as no-update with the data preserved.
    rec_ready = 1'b0;
    drive(32'h400, 5'd0, 32'hDEAD, 1'b1);
    step();
    drive(32'h404, 5'd5, 32'hBEEF, 1'b1);
    step();
    commit_valid = 1'b0;
    check("x0_level", level, 2);
    check("x0_update", rec_update, 0);
    check("x0_data", rec_data, 32'hDEAD);
    check("x0_addr", rec_addr, 0);
    rec_ready = 1'b1;
    step();
    check("x5_update", rec_update, 1);
    check("x5_data", rec_data, 32'hBEEF);
    check("x5_addr", rec_addr, 5);
    step();
    rec_ready = 1'b0;
    check("x0_empty", level, 0);
    check("x0_commit_cnt", commit_cnt, 22);

    // Backpressure: ready toggles every cycle, commits every other cycle.
    stalled = 1'b0; popped = 0; held_pc = '0; held_data = '0;
    for (int i = 0; i < 60; i++) begin
      rec_ready = i[0];
      if (i < 40 && !i[0]) drive(32'h1000 + 32'(4 * i), 5'(i), ~32'(i), 1'b1);
      else commit_valid = 1'b0;
      if (stalled) begin
        check("bp_stable_pc", rec_pc, 64'(held_pc));
        check("bp_stable_data", rec_data, 64'(held_data));
      end
      if (rec_valid && rec_ready) begin
        if (sb_pc.size() == 0) begin
          check("bp_unexpected_rec", rec_pc, 0);
        end else begin
          check("bp_pc", rec_pc, 64'(sb_pc.pop_front()));
          check("bp_data", rec_data, 64'(sb_data.pop_front()));
          check("bp_update", rec_update, 64'(sb_upd.pop_front()));
          popped++;
        end
      end
      stalled   = rec_valid && !rec_ready;
      held_pc   = rec_pc;
      held_data = rec_data;
      if (commit_valid) begin
        sb_pc.push_back(pc);
        sb_data.push_back(reg_data);
        sb_upd.push_back(reg_update && (reg_addr != 5'd0));
      end
      step();
    end
    commit_valid = 1'b0;
    rec_ready    = 1'b0;
    check("bp_popped", popped, 20);
    check("bp_sb_left", sb_pc.size(), 0);
    check("bp_level", level, 0);
    check("bp_drop_cnt", drop_cnt, 2);
    check("bp_commit_cnt", commit_cnt, 42);

    // Clear with five entries held and overflow set.
    for (int i = 0; i < 5; i++) begin
      drive(32'h600 + 32'(4 * i), 5'd7, 32'(i), 1'b1);
      step();
    end
    check("clr_pre_level", level, 5);
    check("clr_pre_overflow", overflow, 1);
    clear = 1'b1;
    drive(32'h700, 5'd7, 32'h7, 1'b1);
    step();
    clear = 1'b0;
    commit_valid = 1'b0;
    check("clr_level", level, 0);
    check("clr_valid", rec_valid, 0);
    check("clr_commit_cnt", commit_cnt, 0);
    check("clr_drop_cnt", drop_cnt, 0);
    check("clr_overflow", overflow, 0);

    // Reset in the middle of a drain takes effect without a clock edge.
    for (int i = 0; i < 3; i++) begin
      drive(32'h500 + 32'(4 * i), 5'd9, 32'hA0 + 32'(i), 1'b1);
      step();
    end
    commit_valid = 1'b0;
    rec_ready = 1'b1;
    step();
    check("mid_pc", rec_pc, 32'h504);
    check("mid_valid", rec_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", rec_valid, 0);
    check("arst_level", level, 0);
    check("arst_pc", rec_pc, 0);
    check("arst_instr", rec_instr, 0);
    check("arst_data", rec_data, 0);
    check("arst_update", rec_update, 0);
    check("arst_commit_cnt", commit_cnt, 0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_valid", rec_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
